// File: rtl/fifo_reader_pkg.sv
// Shared types for the FIFO stream reader and its local skid buffer.
package fifo_reader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } reader_state_t;

endpackage

// File: rtl/fifo_reader_skid.sv
// Small circular buffer between the FIFO read port and the output stream.
// Head is combinational so the stream sees data the cycle after it is pushed.
module fifo_reader_skid
  import fifo_reader_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int BUF_LOG2 = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                push_i,
  input  logic [WIDTH-1:0]    data_i,
  input  logic                pop_i,
  output logic [BUF_LOG2:0]   count_o,
  output logic [WIDTH-1:0]    head_o
);

  localparam int DEPTH = 2 ** BUF_LOG2;
  localparam logic [BUF_LOG2:0]   FULL    = {1'b1, {BUF_LOG2{1'b0}}};
  localparam logic [BUF_LOG2:0]   CNT_ONE = {{BUF_LOG2{1'b0}}, 1'b1};
  localparam logic [BUF_LOG2-1:0] PTR_ONE = {{(BUF_LOG2-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0]    r_mem [DEPTH];
  logic [BUF_LOG2-1:0] r_wr_ptr;
  logic [BUF_LOG2-1:0] r_rd_ptr;
  logic [BUF_LOG2:0]   r_count;
  logic                w_pop;
  logic                w_push;

  // A push into a full buffer is accepted only if a pop frees a slot the same cycle.
  assign w_pop  = pop_i & (r_count != '0);
  assign w_push = push_i & ((r_count != FULL) | w_pop);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= data_i;
        r_wr_ptr        <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  assign count_o = r_count;
  assign head_o  = r_mem[r_rd_ptr];

endmodule

// File: rtl/fifo_stream_reader.sv
// Pops len_i words from a 1-cycle-latency FIFO read port onto a valid/ready stream.
// Define FIFO_READER_LAST_EN to add m_last_o, carried as a tag bit through the skid buffer.
module fifo_stream_reader
  import fifo_reader_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int LEN_WIDTH = 32,
  parameter int BUF_LOG2  = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start_i,
  input  logic [LEN_WIDTH-1:0] len_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o,
  output logic                 rd_re_o,
  input  logic                 rd_empty_i,
  input  logic                 rd_rvalid_i,
  input  logic [WIDTH-1:0]     rd_rdata_i,
  output logic                 m_valid_o,
  output logic [WIDTH-1:0]     m_data_o,
`ifdef FIFO_READER_LAST_EN
  output logic                 m_last_o,
`endif
  input  logic                 m_ready_i
);

`ifdef FIFO_READER_LAST_EN
  localparam int TAG_W = 1;
`else
  localparam int TAG_W = 0;
`endif
  localparam int BUF_W = WIDTH + TAG_W;
  localparam logic [BUF_LOG2+1:0]  DEPTH_C = {2'b01, {BUF_LOG2{1'b0}}};
  localparam logic [LEN_WIDTH-1:0] LEN_ONE = {{(LEN_WIDTH-1){1'b0}}, 1'b1};

  reader_state_t        r_state;
  reader_state_t        w_state_next;
  logic [LEN_WIDTH-1:0] r_len;
  logic [LEN_WIDTH-1:0] r_issued;
  logic [LEN_WIDTH-1:0] r_delivered;
  logic                 r_inflight;
  logic                 r_err;
  logic                 w_acc;
  logic                 w_pop;
  logic [BUF_LOG2:0]    w_count;
  logic [BUF_LOG2+1:0]  w_credit_used;
  logic [BUF_W-1:0]     w_buf_in;
  logic [BUF_W-1:0]     w_buf_head;

  // Slots already committed: buffered words plus the read in flight, less the one leaving now.
  assign w_pop         = m_valid_o & m_ready_i;
  assign w_credit_used = {1'b0, w_count}
                       + {{(BUF_LOG2+1){1'b0}}, r_inflight}
                       - {{(BUF_LOG2+1){1'b0}}, w_pop};
  assign w_acc         = rd_re_o & ~rd_empty_i;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (start_i) w_state_next = (len_i == '0) ? DONE : RUN;
      RUN:     if (r_issued == r_len) w_state_next = DRAIN;
      DRAIN:   if (r_delivered == r_len) w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    busy_o  = (r_state != IDLE);
    done_o  = (r_state == DONE);
    rd_re_o = (r_state == RUN) & (r_issued < r_len) & ~rd_empty_i
            & (w_credit_used < DEPTH_C);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_len       <= '0;
      r_issued    <= '0;
      r_delivered <= '0;
      r_inflight  <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_inflight <= w_acc;
      if (rd_rvalid_i & ~r_inflight) r_err <= 1'b1;
      if ((r_state == IDLE) & start_i) begin
        r_len       <= len_i;
        r_issued    <= '0;
        r_delivered <= '0;
      end else if (r_state != IDLE) begin
        if (w_acc) r_issued    <= r_issued + LEN_ONE;
        if (w_pop) r_delivered <= r_delivered + LEN_ONE;
      end
    end
  end

`ifdef FIFO_READER_LAST_EN
  logic r_last_tag;

  // The tag follows the read by one cycle so it lines up with rd_rvalid_i.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_last_tag <= 1'b0;
    else          r_last_tag <= w_acc & (r_issued == r_len - LEN_ONE);
  end

  assign w_buf_in = {r_last_tag, rd_rdata_i};
  assign m_last_o = m_valid_o & w_buf_head[WIDTH];
`else
  assign w_buf_in = rd_rdata_i;
`endif

  fifo_reader_skid #(
    .WIDTH    (BUF_W),
    .BUF_LOG2 (BUF_LOG2)
  ) u_skid (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (rd_rvalid_i),
    .data_i  (w_buf_in),
    .pop_i   (w_pop),
    .count_o (w_count),
    .head_o  (w_buf_head)
  );

  assign err_o     = r_err;
  assign m_valid_o = (w_count != '0);
  assign m_data_o  = w_buf_head[WIDTH-1:0];

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Scoreboard bench for fifo_stream_reader with a behavioural 1-cycle-latency FIFO model.
module tb_fifo_stream_reader;

  localparam int WIDTH     = 8;
  localparam int LEN_WIDTH = 32;
  localparam int BUF_LOG2  = 1;
  localparam int BUF_DEPTH = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 reset_n = 1'b1;
  logic                 start_i = 1'b0;
  logic [LEN_WIDTH-1:0] len_i = '0;
  logic                 busy, done, err, rd_re, rd_empty, rd_rvalid;
  logic [WIDTH-1:0]     rd_rdata;
  logic                 m_valid, m_ready = 1'b0;
  logic [WIDTH-1:0]     m_data;
`ifdef FIFO_READER_LAST_EN
  logic                 m_last;
`endif

  // FIFO model and spurious-rvalid injection
  logic             model_rvalid = 1'b0;
  logic [WIDTH-1:0] model_rdata = '0;
  logic             spur_rv = 1'b0;
  logic [WIDTH-1:0] spur_data = '0;
  logic             wr_en = 1'b0;
  logic [WIDTH-1:0] wr_data = '0;
  int               fifo_cnt = 0;
  logic [WIDTH-1:0] fifo_q[$];
  logic [WIDTH-1:0] exp_q[$];

  assign rd_empty  = (fifo_cnt == 0);
  assign rd_rvalid = model_rvalid | spur_rv;
  assign rd_rdata  = spur_rv ? spur_data : model_rdata;

  fifo_stream_reader #(
    .WIDTH(WIDTH), .LEN_WIDTH(LEN_WIDTH), .BUF_LOG2(BUF_LOG2)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start_i(start_i), .len_i(len_i),
    .busy_o(busy), .done_o(done), .err_o(err), .rd_re_o(rd_re),
    .rd_empty_i(rd_empty), .rd_rvalid_i(rd_rvalid), .rd_rdata_i(rd_rdata),
    .m_valid_o(m_valid), .m_data_o(m_data),
`ifdef FIFO_READER_LAST_EN
    .m_last_o(m_last),
`endif
    .m_ready_i(m_ready)
  );

  always @(posedge clk) begin
    if (!reset_n) begin
      fifo_q.delete();
      model_rvalid <= 1'b0;
      model_rdata  <= '0;
      fifo_cnt     <= 0;
    end else begin
      model_rvalid <= 1'b0;
      if (rd_re && fifo_q.size() != 0) begin
        model_rdata  <= fifo_q.pop_front();
        model_rvalid <= 1'b1;
      end
      if (wr_en) fifo_q.push_back(wr_data);
      fifo_cnt <= fifo_q.size();
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Monitor: sampled on the falling edge, inputs change only just after the rising edge.
  int cyc = 0;
  int re_cnt, re_first, re_last, viol, beats, beat_first, beat_last, done_cnt, done_cyc;
  int cur_len = 0;
  bit in_xfer = 1'b0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (reset_n) begin
      if (rd_re) begin
        if (re_cnt == 0) re_first = cyc;
        re_last = cyc;
        re_cnt++;
        if (rd_empty) viol++;
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          check("beat_unexpected", 64'(m_data), 64'hdead);
        end else begin
          check("beat_data", 64'(m_data), 64'(exp_q.pop_front()));
`ifdef FIFO_READER_LAST_EN
          check("beat_last", 64'(m_last), 64'(in_xfer && (beats == cur_len - 1)));
`endif
        end
        if (beats == 0) beat_first = cyc;
        beat_last = cyc;
        beats++;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        in_xfer  = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_stats();
    re_cnt = 0; viol = 0; beats = 0; done_cnt = 0;
    re_first = 0; re_last = 0; beat_first = 0; beat_last = 0; done_cyc = 0;
  endtask

  task automatic fifo_write(input logic [WIDTH-1:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    exp_q.push_back(d);
    tick();
    wr_en = 1'b0;
  endtask

  task automatic start_xfer(input int len);
    start_i = 1'b1;
    len_i   = LEN_WIDTH'(len);
    cur_len = len;
    in_xfer = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget);
    int k = 0;
    while (done_cnt < target && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("done_timeout", 64'(done_cnt >= target), 64'd1);
  endtask

  task automatic check_outs_zero(input string tag);
    check(tag, 64'({busy, done, err, rd_re, m_valid, m_data}), 64'd0);
`ifdef FIFO_READER_LAST_EN
    check({tag, "_last"}, 64'(m_last), 64'd0);
`endif
  endtask

  initial begin
    clear_stats();
    // 1: asynchronous reset, then inputs toggling under reset
    #2 reset_n = 1'b0;
    #1 check_outs_zero("t1_async_reset");
    repeat (4) begin
      tick();
      start_i   = 1'($urandom_range(0, 1));
      m_ready   = 1'($urandom_range(0, 1));
      spur_rv   = 1'($urandom_range(0, 1));
      spur_data = WIDTH'($urandom);
      len_i     = LEN_WIDTH'($urandom);
    end
    @(negedge clk);
    check_outs_zero("t1_reset_toggle");
    tick();
    start_i = 1'b0; m_ready = 1'b0; spur_rv = 1'b0; len_i = '0;
    reset_n = 1'b1;
    tick();

    // 2: four words, stream always ready
    clear_stats();
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) fifo_write(WIDTH'(8'hA1 + i));
    start_xfer(4);
    wait_done(1, 40);
    repeat (2) tick();
    check("t2_re_cnt", 64'(re_cnt), 64'd4);
    check("t2_re_span", 64'(re_last - re_first), 64'd3);
    check("t2_beats", 64'(beats), 64'd4);
    check("t2_beat_span", 64'(beat_last - beat_first), 64'd3);
    check("t2_done_lat", 64'(done_cyc - beat_last), 64'd2);
    check("t2_done_cnt", 64'(done_cnt), 64'd1);
    check("t2_busy", 64'(busy), 64'd0);
    check("t2_exp_empty", 64'(exp_q.size()), 64'd0);

    // 3: backpressure, only BUF_DEPTH reads may be outstanding
    clear_stats();
    m_ready = 1'b0;
    for (int i = 0; i < 8; i++) fifo_write(WIDTH'(8'h31 + i));
    start_xfer(8);
    repeat (10) tick();
    check("t3_re_stalled", 64'(re_cnt), 64'(BUF_DEPTH));
    @(negedge clk);
    check("t3_hold_valid", 64'(m_valid), 64'd1);
    check("t3_hold_data", 64'(m_data), 64'h31);
    tick();
    m_ready = 1'b1;
    wait_done(1, 60);
    repeat (2) tick();
    check("t3_beats", 64'(beats), 64'd8);
    check("t3_beat_span", 64'(beat_last - beat_first), 64'd7);
    check("t3_done_cnt", 64'(done_cnt), 64'd1);
    check("t3_exp_empty", 64'(exp_q.size()), 64'd0);

    // 4: starved FIFO, one word every third cycle
    clear_stats();
    m_ready = 1'b1;
    start_xfer(3);
    for (int i = 0; i < 3; i++) begin
      repeat (2) tick();
      fifo_write(WIDTH'(8'h51 + i));
    end
    wait_done(1, 40);
    repeat (2) tick();
    check("t4_re_while_empty", 64'(viol), 64'd0);
    check("t4_re_cnt", 64'(re_cnt), 64'd3);
    check("t4_beats", 64'(beats), 64'd3);
    check("t4_done_cnt", 64'(done_cnt), 64'd1);
    check("t4_exp_empty", 64'(exp_q.size()), 64'd0);

    // 5: zero length, then start ignored while busy
    clear_stats();
    start_xfer(0);
    @(negedge clk);
    check("t5_done_pulse", 64'(done), 64'd1);
    tick();
    check("t5_done_low", 64'(done), 64'd0);
    check("t5_idle", 64'(busy), 64'd0);
    check("t5_no_re", 64'(re_cnt), 64'd0);
    check("t5_done_cnt", 64'(done_cnt), 64'd1);

    clear_stats();
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) fifo_write(WIDTH'(8'h61 + i));
    start_xfer(2);
    repeat (4) tick();
    start_i = 1'b1;
    len_i   = LEN_WIDTH'(5);
    tick();
    start_i = 1'b0;
    m_ready = 1'b1;
    wait_done(1, 40);
    repeat (2) tick();
    check("t5_ign_beats", 64'(beats), 64'd2);
    check("t5_ign_re_cnt", 64'(re_cnt), 64'd2);
    check("t5_ign_fifo_left", 64'(fifo_cnt), 64'd2);
    check("t5_ign_done_cnt", 64'(done_cnt), 64'd1);
    check("t5_ign_idle", 64'(busy), 64'd0);

    clear_stats();
    start_xfer(2);
    wait_done(1, 40);
    repeat (2) tick();
    check("t5_flush_beats", 64'(beats), 64'd2);
    check("t5_flush_exp_empty", 64'(exp_q.size()), 64'd0);

    // 6: spurious rvalid sets a sticky error; the word is still delivered
    clear_stats();
    m_ready = 1'b1;
    check("t6_err_pre", 64'(err), 64'd0);
    spur_data = 8'hE5;
    spur_rv   = 1'b1;
    exp_q.push_back(8'hE5);
    tick();
    spur_rv = 1'b0;
    tick();
    check("t6_err_set", 64'(err), 64'd1);
    check("t6_spur_beat", 64'(beats), 64'd1);
    repeat (5) tick();
    check("t6_err_sticky", 64'(err), 64'd1);

    // Reset asserted mid-cycle during a stalled transfer clears everything without a clock
    clear_stats();
    m_ready = 1'b0;
    for (int i = 0; i < 3; i++) fifo_write(WIDTH'(8'h71 + i));
    start_xfer(3);
    repeat (3) tick();
    check("t6_busy_pre", 64'(busy), 64'd1);
    check("t6_valid_pre", 64'(m_valid), 64'd1);
    #2 reset_n = 1'b0;
    #1 check_outs_zero("t6_async_midcycle");
    exp_q.delete();
    in_xfer = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
